// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and helpers for the sized data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Access size as carried on req_size
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } dmem_size_e;

  // Post-reset clear sequencer states
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

  // Widest word supported is 64 bits, i.e. eight byte lanes
  localparam int c_MAX_LANES = 8;

  // Byte-enable pattern for an access of the given size starting at the given
  // lane. Bits that land above the real word width flag a word-crossing access.
  function automatic logic [c_MAX_LANES-1:0] byte_mask(input dmem_size_e size,
                                                       input logic [2:0] lane);
    logic [c_MAX_LANES-1:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_load_align
// Description : Extracts the addressed lanes of a memory word, right-aligns
//               them and sign- or zero-extends to the full word width.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [LANE_W-1:0]     i_lane,
  input  dmem_size_e            i_size,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_word_ext;

  assign w_shifted = i_word >> {i_lane, 3'b000};

  // A 32-bit load only needs extending when the word itself is wider
  generate
    if (DATA_WIDTH > 32) begin : g_word_ext
      assign w_word_ext = {{(DATA_WIDTH-32){~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
    end else begin : g_word_full
      assign w_word_ext = w_shifted;
    end
  endgenerate

  // Select the extension that matches the access size
  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SZ_B:    o_data = {{(DATA_WIDTH-8){~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_data = {{(DATA_WIDTH-16){~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      SZ_W:    o_data = w_word_ext;
      default: o_data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_sized.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_sized
// Description : Byte-addressed data memory with sized/sign-extended loads,
//               byte-lane stores, valid/ready request port, fixed-latency
//               in-order responses, error signalling and post-reset clear.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int RD_LATENCY   = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int c_NB    = DATA_WIDTH / 8;
  localparam int c_OFS   = $clog2(c_NB);
  localparam int c_IDX_W = $clog2(MEM_WORDS);
  localparam int c_TOP   = c_IDX_W + c_OFS;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(MEM_WORDS - 1);

  // ---------------------------------------------------------------- clear FSM
  dmem_state_e          r_state;
  dmem_state_e          w_state_nxt;
  logic [c_IDX_W-1:0]   r_clr_idx;
  logic [c_IDX_W-1:0]   w_clr_idx_nxt;
  logic                 w_clr_we;
  logic                 w_ready;
  logic                 w_acc;

  // State and clear-index registers; reset restarts the clear from word 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Walk the array one word per cycle, then open the request port
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_idx == c_LAST_IDX) begin
          w_state_nxt = ST_READY;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Ready is gated by rst so nothing is accepted while reset is held
  assign w_ready   = (r_state == ST_READY) && !rst;
  assign req_ready = w_ready;
  assign w_acc     = req_valid && w_ready;

  // ----------------------------------------------------------- request decode
  dmem_size_e              w_size;
  logic [c_IDX_W-1:0]      w_idx;
  logic [c_OFS-1:0]        w_lane;
  logic [c_MAX_LANES-1:0]  w_mask8;
  logic [c_NB-1:0]         w_be;
  logic                    w_misalign;
  logic                    w_bad_size;
  logic                    w_cross;
  logic                    w_oob;
  logic                    w_err;
  logic                    w_st;
  logic [DATA_WIDTH-1:0]   w_wdata_sh;

  assign w_size     = dmem_size_e'(req_size);
  assign w_idx      = req_addr[c_TOP-1:c_OFS];
  assign w_lane     = req_addr[c_OFS-1:0];
  assign w_mask8    = byte_mask(w_size, 3'(w_lane));
  assign w_be       = w_mask8[c_NB-1:0];
  assign w_cross    = |(w_mask8 >> c_NB);
  assign w_wdata_sh = req_wdata << {w_lane, 3'b000};

  // Natural alignment per size; dword only exists on 64-bit words
  always_comb begin
    w_misalign = 1'b0;
    w_bad_size = 1'b0;
    case (w_size)
      SZ_H: w_misalign = req_addr[0];
      SZ_W: w_misalign = |req_addr[1:0];
      SZ_D: begin
        w_misalign = |req_addr[2:0];
        w_bad_size = (DATA_WIDTH == 32);
      end
      default: ;
    endcase
  end

  // MEM_WORDS is a power of two, so out-of-range means any bit above the array
  generate
    if (ADDR_WIDTH > c_TOP) begin : g_oob
      assign w_oob = |req_addr[ADDR_WIDTH-1:c_TOP];
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  assign w_err = w_misalign | w_bad_size | w_cross | w_oob;
  assign w_st  = w_acc && req_we && !w_err;

  // -------------------------------------------------------------------- array
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] w_rword;
  logic [DATA_WIDTH-1:0] w_ld_data;

  // Clear writes and byte-enabled stores; the two never coincide since the
  // port is closed while clearing
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_st) begin
      for (int b = 0; b < c_NB; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
        end
      end
    end
  end

  assign w_rword = r_mem[w_idx];

  dmem_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .i_word     (w_rword),
    .i_lane     (w_lane),
    .i_size     (w_size),
    .i_unsigned (req_unsigned),
    .o_data     (w_ld_data)
  );

  // ------------------------------------------------------------ response pipe
  logic                  w_in_v;
  logic                  w_in_e;
  logic [DATA_WIDTH-1:0] w_in_d;
  logic                  w_tail_v;
  logic                  w_tail_e;
  logic [DATA_WIDTH-1:0] w_tail_d;

  assign w_in_v = w_acc;
  assign w_in_e = w_err;
  assign w_in_d = (req_we || w_err) ? '0 : w_ld_data;

  // RD_LATENCY-1 delay stages ahead of the output register
  generate
    if (RD_LATENCY > 1) begin : g_pipe
      logic                  r_pv [RD_LATENCY-1];
      logic                  r_pe [RD_LATENCY-1];
      logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY-1];

      // Shift responses toward the output; reset drops everything in flight
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RD_LATENCY-1; i++) begin
            r_pv[i] <= 1'b0;
            r_pe[i] <= 1'b0;
            r_pd[i] <= '0;
          end
        end else begin
          r_pv[0] <= w_in_v;
          r_pe[0] <= w_in_e;
          r_pd[0] <= w_in_d;
          for (int i = 1; i < RD_LATENCY-1; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pe[i] <= r_pe[i-1];
            r_pd[i] <= r_pd[i-1];
          end
        end
      end

      assign w_tail_v = r_pv[RD_LATENCY-2];
      assign w_tail_e = r_pe[RD_LATENCY-2];
      assign w_tail_d = r_pd[RD_LATENCY-2];
    end else begin : g_direct
      assign w_tail_v = w_in_v;
      assign w_tail_e = w_in_e;
      assign w_tail_d = w_in_d;
    end
  endgenerate

  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // Output stage: valid pulses, data/err hold until the next response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_tail_v;
      if (w_tail_v) begin
        r_rsp_err   <= w_tail_e;
        r_rsp_rdata <= w_tail_d;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sized.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_sized
// Description : Directed self-checking bench for data_memory_sized
//               (32-bit words, 16 words deep, 3-cycle response latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  // Burst stimulus table
  logic        b_we  [4];
  logic [31:0] b_addr[4];
  logic [1:0]  b_sz  [4];
  logic        b_uns [4];
  logic [31:0] b_wd  [4];
  logic [31:0] b_exp [4];

  data_memory_sized #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .MEM_WORDS    (16),
    .RD_LATENCY   (3),
    .CLEAR_ON_RST (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Single request issued at a falling edge; checks latency, data and error
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int   n;
    logic got;
    drive(we, addr, sz, uns, wd);
    @(posedge clk);
    #1;
    idle();
    n   = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_data"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), {31'd0, exp_e});
  endtask

  // Pulse reset from the current falling edge, check reset outputs, then
  // count cycles until ready and confirm no response appears meanwhile
  task automatic reset_and_count(input string tag);
    int   n;
    logic seen;
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rst_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rst_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rst_err"}, 32'(rsp_err), 32'd0);
    rst  = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (req_ready !== 1'b1 && n < 100) begin
      n++;
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_clear_cycles"}, 32'(n), 32'd16);
    chk({tag, "_no_rsp"}, 32'(seen), 32'd0);
  endtask

  // Requests on consecutive cycles; responses expected on cycles 3..n+2
  task automatic burst(input string tag, input int nreq);
    for (int k = 0; k < nreq + 5; k++) begin
      if (k >= 3 && k < nreq + 3) begin
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, rsp_rdata, b_exp[k-3]);
      end else begin
        chk({tag, "_idle"}, 32'(rsp_valid), 32'd0);
      end
      if (k < nreq) drive(b_we[k], b_addr[k], b_sz[k], b_uns[k], b_wd[k]);
      else idle();
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Initial reset and full clear
    reset_and_count("init");

    // Every word reads back zero after the clear
    for (int i = 0; i < 16; i++) begin
      xact("clr_ld", 1'b0, 32'(i * 4), 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    end

    // Sized loads with sign and zero extension
    xact("sw10", 1'b1, 32'h10, 2'd2, 1'b0, 32'h80FF7F01, 32'd0, 1'b0);
    xact("lb13", 1'b0, 32'h13, 2'd0, 1'b0, 32'd0, 32'hFFFFFF80, 1'b0);
    xact("lbu13", 1'b0, 32'h13, 2'd0, 1'b1, 32'd0, 32'h00000080, 1'b0);
    xact("lh12", 1'b0, 32'h12, 2'd1, 1'b0, 32'd0, 32'hFFFF80FF, 1'b0);
    xact("lhu10", 1'b0, 32'h10, 2'd1, 1'b1, 32'd0, 32'h00007F01, 1'b0);
    xact("lb11", 1'b0, 32'h11, 2'd0, 1'b0, 32'd0, 32'h0000007F, 1'b0);

    // Partial writes touch only the addressed lanes
    xact("sw20", 1'b1, 32'h20, 2'd2, 1'b0, 32'h11223344, 32'd0, 1'b0);
    xact("sb21", 1'b1, 32'h21, 2'd0, 1'b0, 32'h000000AA, 32'd0, 1'b0);
    xact("lw20a", 1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 32'h1122AA44, 1'b0);
    xact("sh22", 1'b1, 32'h22, 2'd1, 1'b0, 32'h0000BEEF, 32'd0, 1'b0);
    xact("lw20b", 1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 32'hBEEFAA44, 1'b0);

    // Error cases leave memory untouched
    xact("sw00", 1'b1, 32'h00, 2'd2, 1'b0, 32'h12345678, 32'd0, 1'b0);
    xact("lh01", 1'b0, 32'h01, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("hold_err", 32'(rsp_err), 32'd1);
    chk("hold_valid", 32'(rsp_valid), 32'd0);
    xact("lw02", 1'b0, 32'h02, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1);
    xact("sw40", 1'b1, 32'h40, 2'd2, 1'b0, 32'hDEADBEEF, 32'd0, 1'b1);
    xact("sh01", 1'b1, 32'h01, 2'd1, 1'b0, 32'h0000FFFF, 32'd0, 1'b1);
    xact("ld08", 1'b0, 32'h08, 2'd3, 1'b0, 32'd0, 32'd0, 1'b1);
    xact("lw00", 1'b0, 32'h00, 2'd2, 1'b0, 32'd0, 32'h12345678, 1'b0);

    // Four back-to-back loads, responses in order
    b_we[0] = 1'b0; b_addr[0] = 32'h10; b_sz[0] = 2'd2; b_uns[0] = 1'b0; b_wd[0] = '0; b_exp[0] = 32'h80FF7F01;
    b_we[1] = 1'b0; b_addr[1] = 32'h20; b_sz[1] = 2'd2; b_uns[1] = 1'b0; b_wd[1] = '0; b_exp[1] = 32'hBEEFAA44;
    b_we[2] = 1'b0; b_addr[2] = 32'h00; b_sz[2] = 2'd2; b_uns[2] = 1'b0; b_wd[2] = '0; b_exp[2] = 32'h12345678;
    b_we[3] = 1'b0; b_addr[3] = 32'h23; b_sz[3] = 2'd0; b_uns[3] = 1'b1; b_wd[3] = '0; b_exp[3] = 32'h000000BE;
    @(negedge clk);
    burst("b2b", 4);

    // Store then load of the same word on the next cycle
    b_we[0] = 1'b1; b_addr[0] = 32'h30; b_sz[0] = 2'd2; b_uns[0] = 1'b0; b_wd[0] = 32'hCAFEF00D; b_exp[0] = 32'd0;
    b_we[1] = 1'b0; b_addr[1] = 32'h30; b_sz[1] = 2'd2; b_uns[1] = 1'b0; b_wd[1] = '0;           b_exp[1] = 32'hCAFEF00D;
    burst("raw", 2);

    // Reset during clear at index 5 restarts the full clear
    xact("sw3c", 1'b1, 32'h3C, 2'd2, 1'b0, 32'h55AA55AA, 32'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_clear_ready", 32'(req_ready), 32'd0);
    reset_and_count("restart");
    xact("post_lw00", 1'b0, 32'h00, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    xact("post_lw3c", 1'b0, 32'h3C, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);

    // Reset with two responses in flight drops them
    @(negedge clk);
    drive(1'b0, 32'h00, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h04, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    reset_and_count("flight");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
